// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite draw/erase engines.
package sprite_pkg;

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_WHITE = 3'b111;

  localparam int SCR_W = 320;
  localparam int SCR_H = 240;

endpackage

// File: rtl/sprite_mover_if.sv
// Pixel plot channel: one pixel per plot && pix_ready handshake.
interface sprite_mover_if #(
  parameter int X_W = 9,
  parameter int Y_W = 8
);
  logic           plot;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [2:0]     colour;
  logic           pix_ready;

  modport master (output plot, x_out, y_out, colour, input pix_ready);
  modport slave  (input plot, x_out, y_out, colour, output pix_ready);
endinterface

// File: rtl/sprite_scan_counter.sv
// Raster scan over a W x H sprite: col runs fastest, wraps to 0,0 after the last pixel.
// Advances only on 'advance'; 'clear' has priority; 'last' is combinational.
module sprite_scan_counter #(
  parameter int W = 10,
  parameter int H = 4,
  localparam int CW = (W > 1) ? $clog2(W) : 1,
  localparam int RW = (H > 1) ? $clog2(H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/sprite_mover.sv
// Per frame_tick: erase sprite at old x, apply one clamped move step, redraw at new x.
// Pixels leave one per accepted handshake; pix_ready low stalls the scan with outputs held.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int         SPR_W   = 10,
  parameter int         SPR_H   = 4,
  parameter int         SCR_W   = sprite_pkg::SCR_W,
  parameter int         X_W     = 9,
  parameter int         Y_W     = 8,
  parameter int         X_INIT  = 0,
  parameter int         Y_POS   = 0,
  parameter int         STEP    = 1,
  parameter logic [2:0] C_DRAW  = C_WHITE,
  parameter logic [2:0] C_ERASE = C_BLACK
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 left,
  input  logic                 right,
  sprite_mover_if.master       pix,
  output logic                 busy,
  output logic                 done,
  output logic [X_W-1:0]       pos_x
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [X_W-1:0] X_INIT_V = X_W'(X_INIT);
  localparam logic [X_W:0]   STEP_W   = (X_W + 1)'(STEP);
  localparam logic [X_W:0]   XMAX_W   = (X_W + 1)'(SCR_W - SPR_W);

  state_t         state, state_nxt;
  logic           drawn, drawn_nxt;
  logic [X_W-1:0] pos_x_nxt;
  logic           clear, advance, last, accept;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [X_W:0]   wide_x, moved;

  sprite_scan_counter #(.W(SPR_W), .H(SPR_H)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      drawn <= 1'b0;
      pos_x <= X_INIT_V;
    end else begin
      state <= state_nxt;
      drawn <= drawn_nxt;
      pos_x <= pos_x_nxt;
    end
  end

  assign accept = pix.plot && pix.pix_ready;

  always_comb begin
    state_nxt = state;
    drawn_nxt = drawn;
    pos_x_nxt = pos_x;
    clear     = 1'b0;
    advance   = 1'b0;
    wide_x    = {1'b0, pos_x};
    moved     = wide_x;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          clear     = 1'b1;
          state_nxt = drawn ? ERASE : DRAW;
        end
      end
      ERASE: begin
        if (accept) begin
          advance = 1'b1;
          if (last) state_nxt = MOVE;
        end
      end
      MOVE: begin
        // Extra top bit keeps both clamps free of wrap-around.
        if (left && !right)
          moved = (wide_x >= STEP_W) ? wide_x - STEP_W : '0;
        else if (right && !left)
          moved = (wide_x + STEP_W <= XMAX_W) ? wide_x + STEP_W : XMAX_W;
        pos_x_nxt = X_W'(moved);
        clear     = 1'b1;
        state_nxt = DRAW;
      end
      DRAW: begin
        if (accept) begin
          advance = 1'b1;
          if (last) begin
            state_nxt = DONE;
            drawn_nxt = 1'b1;
            clear     = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pix.plot   = (state == ERASE) || (state == DRAW);
  assign pix.x_out  = pos_x + X_W'(col);
  assign pix.y_out  = Y_W'(Y_POS) + Y_W'(row);
  assign pix.colour = (state == DRAW) ? C_DRAW : C_ERASE;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule
